// File: rtl/uint16_rpn_controller_pkg.sv
// Shared types for the UInt16 RPN controller and its ALU.
package uint16_rpn_controller_pkg;

  typedef logic [15:0] uint16_t;

  typedef enum logic [2:0] {
    OP_PUSH  = 3'd0,
    OP_ADD   = 3'd1,
    OP_SUB   = 3'd2,
    OP_MUL   = 3'd3,
    OP_DIV   = 3'd4,
    OP_POP   = 3'd5,
    OP_CLEAR = 3'd6,
    OP_BAD   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_OK        = 3'd0,
    ST_OVERFLOW  = 3'd1,
    ST_UNDERFLOW = 3'd2,
    ST_DIV_ZERO  = 3'd3,
    ST_BAD_OP    = 3'd4
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EXEC   = 2'd2,
    S_COMMIT = 2'd3
  } state_e;

  function automatic logic is_arith(op_e op);
    return (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Errors that can be decided from depth alone, before any operand read.
  function automatic status_e check_cmd(op_e op, logic full,
                                        logic lt2, logic empty);
    status_e s;
    s = ST_OK;
    if (op == OP_BAD) s = ST_BAD_OP;
    else if (op == OP_PUSH && full) s = ST_OVERFLOW;
    else if (is_arith(op) && lt2) s = ST_UNDERFLOW;
    else if (op == OP_POP && empty) s = ST_UNDERFLOW;
    return s;
  endfunction

endpackage

// File: rtl/uint16_rpn_controller_alu.sv
// Combinational UInt16 arithmetic unit with one-hot operation select.
module uint16_alu
  import uint16_rpn_controller_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        add,
  input  logic        subtract,
  input  logic        divide,
  input  logic        multiply,
  output logic [15:0] result,
  output logic        invalid_input
);

  always_comb begin
    result = '0;
    unique case (1'b1)
      add:      result = a + b;
      subtract: result = a - b;
      multiply: result = a * b;
      divide:   result = (b == '0) ? '1 : a / b;
      default:  result = '0;
    endcase
  end

  assign invalid_input =
    ($countones({add, subtract, divide, multiply}) != 1);

endmodule

// File: rtl/uint16_rpn_controller.sv
// RPN stack-machine front-end driving the UInt16 ALU.
module uint16_rpn_controller
  import uint16_rpn_controller_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int DW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [15:0]   cmd_data,
  output logic [15:0]   top,
  output logic [DW-1:0] depth,
  output logic          resp_valid,
  output logic [2:0]    resp_status
);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  uint16_t       data_q, data_d;
  status_e       pend_q, pend_d;
  uint16_t       a_q, a_d;
  uint16_t       b_q, b_d;
  uint16_t       res_q, res_d;
  uint16_t       stack_q [DEPTH];
  uint16_t       stack_d [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic          resp_valid_q, resp_valid_d;
  status_e       resp_status_q, resp_status_d;

  logic          sel_add, sel_sub, sel_mul, sel_div;
  uint16_t       alu_result;
  logic          alu_invalid;
  logic [IW-1:0] top_idx, sec_idx, push_idx;
  op_e           cmd_op_e;

  assign push_idx = depth_q[IW-1:0];
  assign top_idx  = depth_q[IW-1:0] - IW'(1);
  assign sec_idx  = depth_q[IW-1:0] - IW'(2);
  assign cmd_op_e = op_e'(cmd_op);

  uint16_alu u_alu (
    .a             (a_q),
    .b             (b_q),
    .add           (sel_add),
    .subtract      (sel_sub),
    .divide        (sel_div),
    .multiply      (sel_mul),
    .result        (alu_result),
    .invalid_input (alu_invalid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= OP_PUSH;
      data_q        <= '0;
      pend_q        <= ST_OK;
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      depth_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= ST_OK;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      data_q        <= data_d;
      pend_q        <= pend_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_q         <= res_d;
      depth_q       <= depth_d;
      resp_valid_q  <= resp_valid_d;
      resp_status_q <= resp_status_d;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    data_d        = data_q;
    pend_d        = pend_q;
    a_d           = a_q;
    b_d           = b_q;
    res_d         = res_q;
    depth_d       = depth_q;
    resp_valid_d  = 1'b0;
    resp_status_d = resp_status_q;
    for (int i = 0; i < DEPTH; i++) stack_d[i] = stack_q[i];

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op_e;
          data_d = cmd_data;
          pend_d = check_cmd(cmd_op_e,
                             depth_q == DW'(DEPTH),
                             depth_q < DW'(2),
                             depth_q == '0);
          if (pend_d == ST_OK && is_arith(cmd_op_e))
            state_d = S_LOAD;
          else
            state_d = S_COMMIT;
        end
      end
      S_LOAD: begin
        a_d     = stack_q[sec_idx];
        b_d     = stack_q[top_idx];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = alu_result;
        if (op_q == OP_DIV && b_q == '0) pend_d = ST_DIV_ZERO;
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        resp_valid_d  = 1'b1;
        resp_status_d = pend_q;
        state_d       = S_IDLE;
        if (pend_q == ST_OK) begin
          unique case (op_q)
            OP_PUSH: begin
              stack_d[push_idx] = data_q;
              depth_d = depth_q + DW'(1);
            end
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
              stack_d[sec_idx] = res_q;
              depth_d = depth_q - DW'(1);
            end
            OP_POP:   depth_d = depth_q - DW'(1);
            OP_CLEAR: depth_d = '0;
            default:  depth_d = depth_q;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state_q == S_IDLE);
    sel_add     = (state_q == S_EXEC) && (op_q == OP_ADD);
    sel_sub     = (state_q == S_EXEC) && (op_q == OP_SUB);
    sel_mul     = (state_q == S_EXEC) && (op_q == OP_MUL);
    sel_div     = (state_q == S_EXEC) && (op_q == OP_DIV);
    top         = (depth_q == '0) ? '0 : stack_q[top_idx];
    depth       = depth_q;
    resp_valid  = resp_valid_q;
    resp_status = resp_status_q;
  end

endmodule
